// File: rtl/ghost_collision_monitor_pkg.sv
// Shared game constants: screen geometry, coordinate widths and the
// encoding of the collision/life FSM states.
package ghost_collision_monitor_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE     = 20;
    localparam int XW       = $clog2(SCREEN_W);
    localparam int YW       = $clog2(SCREEN_H);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESPAWN = 3'd1;
    localparam logic [2:0] ST_GRACE   = 3'd2;
    localparam logic [2:0] ST_PLAY    = 3'd3;
    localparam logic [2:0] ST_HIT     = 3'd4;
    localparam logic [2:0] ST_OVER    = 3'd5;

endpackage

// File: rtl/proximity_cmp.sv
// One ghost against the player: catch when both |dx| and |dy| are within
// HIT_DIST. Differences carry one extra bit so they never wrap.
module proximity_cmp
    import ghost_collision_monitor_pkg::*;
#(
    parameter int HIT_DIST = 10
) (
    input  logic [XW-1:0] player_x,
    input  logic [YW-1:0] player_y,
    input  logic [XW-1:0] ghost_x,
    input  logic [YW-1:0] ghost_y,
    output logic          hit
);

    logic [XW:0] dx;
    logic [YW:0] dy;

    always_comb begin
        dx  = (player_x >= ghost_x) ? ({1'b0, player_x} - {1'b0, ghost_x})
                                    : ({1'b0, ghost_x} - {1'b0, player_x});
        dy  = (player_y >= ghost_y) ? ({1'b0, player_y} - {1'b0, ghost_y})
                                    : ({1'b0, ghost_y} - {1'b0, player_y});
        hit = (dx <= (XW+1)'(HIT_DIST)) && (dy <= (YW+1)'(HIT_DIST));
    end

endmodule

// File: rtl/ghost_collision_monitor.sv
// Detects the player being caught by any ghost and runs the life/death
// sequence (freeze, countdown, respawn, lives, game over).
module ghost_collision_monitor
    import ghost_collision_monitor_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int HIT_DIST     = 10,
    parameter int START_LIVES  = 3,
    parameter int LIVES_W      = 2,
    parameter int FREEZE_TICKS = 60,
    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1,
    localparam int CW = $clog2(FREEZE_TICKS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic [XW-1:0]            player_x,
    input  logic [YW-1:0]            player_y,
    input  logic [NUM_GHOSTS*XW-1:0] ghost_x_flat,
    input  logic [NUM_GHOSTS*YW-1:0] ghost_y_flat,
    output logic                     freeze,
    output logic                     respawn,
    output logic                     hit_pulse,
    output logic [GW-1:0]            hit_ghost,
    output logic [LIVES_W-1:0]       lives,
    output logic                     game_over,
    output logic [2:0]               state
);

    logic [NUM_GHOSTS-1:0] hit_comb;
    logic [NUM_GHOSTS-1:0] hit_vec_q;
    logic                  any_hit;
    logic [GW-1:0]         first_ghost;
    logic [2:0]            state_q;
    logic [LIVES_W-1:0]    lives_q;
    logic [CW-1:0]         cnt_q;
    logic                  hit_pulse_q;
    logic [GW-1:0]         hit_ghost_q;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_cmp
        proximity_cmp #(.HIT_DIST(HIT_DIST)) u_cmp (
            .player_x (player_x),
            .player_y (player_y),
            .ghost_x  (ghost_x_flat[g*XW +: XW]),
            .ghost_y  (ghost_y_flat[g*YW +: YW]),
            .hit      (hit_comb[g])
        );
    end

    assign any_hit = |hit_vec_q;

    // Scan from the top down so the lowest hitting index is left standing.
    always_comb begin
        first_ghost = '0;
        for (int g = NUM_GHOSTS - 1; g >= 0; g--) begin
            if (hit_vec_q[g]) first_ghost = GW'(g);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lives_q     <= '0;
            cnt_q       <= '0;
            hit_pulse_q <= 1'b0;
            hit_ghost_q <= '0;
            hit_vec_q   <= '0;
        end else begin
            hit_vec_q   <= hit_comb;
            hit_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q <= ST_RESPAWN;
                        lives_q <= LIVES_W'(START_LIVES);
                    end
                end
                ST_RESPAWN: state_q <= ST_GRACE;
                // One tick here lets the compare pipeline see reloaded positions.
                ST_GRACE: if (tick) state_q <= ST_PLAY;
                ST_PLAY: begin
                    if (any_hit) begin
                        state_q     <= ST_HIT;
                        hit_pulse_q <= 1'b1;
                        hit_ghost_q <= first_ghost;
                        lives_q     <= lives_q - LIVES_W'(1);
                        cnt_q       <= CW'(FREEZE_TICKS);
                    end
                end
                ST_HIT: begin
                    if (tick) begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q <= CW'(1)) begin
                            state_q <= (lives_q == '0) ? ST_OVER : ST_RESPAWN;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign freeze    = !(state_q == ST_GRACE || state_q == ST_PLAY);
    assign respawn   = (state_q == ST_RESPAWN);
    assign game_over = (state_q == ST_OVER);
    assign hit_pulse = hit_pulse_q;
    assign hit_ghost = hit_ghost_q;
    assign lives     = lives_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ghost_collision_monitor.sv
// Bench for ghost_collision_monitor: a table of position vectors drives the
// catch logic, hand sequences cover the multi-cycle life/death corners.
module tb_ghost_collision_monitor;

    localparam int NG = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_RESPAWN = 3'd1, S_GRACE = 3'd2,
                           S_PLAY = 3'd3, S_HIT = 3'd4, S_OVER = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  player_x = 10'd100;
    logic [8:0]  player_y = 9'd100;
    logic [39:0] ghost_x_flat;
    logic [35:0] ghost_y_flat;
    logic        freeze, respawn, hit_pulse, game_over;
    logic [1:0]  hit_ghost, lives;
    logic [2:0]  state;

    ghost_collision_monitor #(
        .NUM_GHOSTS(NG), .HIT_DIST(10), .START_LIVES(3), .LIVES_W(2), .FREEZE_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .player_x(player_x), .player_y(player_y),
        .ghost_x_flat(ghost_x_flat), .ghost_y_flat(ghost_y_flat),
        .freeze(freeze), .respawn(respawn), .hit_pulse(hit_pulse),
        .hit_ghost(hit_ghost), .lives(lives), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  px;
        logic [8:0]  py;
        logic [39:0] gxf;
        logic [35:0] gyf;
        logic        exp_hit;
        logic [1:0]  exp_ghost;
    } vec_t;

    vec_t       vecs[7];
    logic [2:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         model_lives = 0;
    logic       model_over = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    function automatic logic [39:0] far_x();
        logic [39:0] f;
        for (int g = 0; g < NG; g++) f[g*10 +: 10] = 10'd600;
        return f;
    endfunction

    function automatic logic [35:0] far_y();
        logic [35:0] f;
        for (int g = 0; g < NG; g++) f[g*9 +: 9] = 9'(300 + 40 * g);
        return f;
    endfunction

    task automatic all_far();
        ghost_x_flat = far_x();
        ghost_y_flat = far_y();
    endtask

    task automatic put_ghost(input int g, input int x, input int y);
        ghost_x_flat[g*10 +: 10] = 10'(x);
        ghost_y_flat[g*9 +: 9]   = 9'(y);
    endtask

    // gb < 0 means only one ghost is placed near the player.
    function automatic vec_t mkv(input string name, input int px, input int py,
                                 input int ga, input int gax, input int gay,
                                 input int gb, input int gbx, input int gby,
                                 input logic h, input int eg);
        vec_t v;
        v.name = name;
        v.px = 10'(px);
        v.py = 9'(py);
        v.gxf = far_x();
        v.gyf = far_y();
        v.gxf[ga*10 +: 10] = 10'(gax);
        v.gyf[ga*9 +: 9]   = 9'(gay);
        if (gb >= 0) begin
            v.gxf[gb*10 +: 10] = 10'(gbx);
            v.gyf[gb*9 +: 9]   = 9'(gby);
        end
        v.exp_hit = h;
        v.exp_ghost = 2'(eg);
        return v;
    endfunction

    // Start from IDLE/OVER; start stays high through GRACE and must not re-trigger.
    task automatic restart();
        start = 1'b1;
        cyc(1'b0);
        check("restart_respawn", respawn, 1);
        check("restart_lives", lives, 3);
        check("restart_game_over", game_over, 0);
        model_lives = 3;
        model_over = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("start_held_once_state", state, S_GRACE);
        check("start_held_once_respawn", respawn, 0);
        start = 1'b0;
        cyc(1'b1);
        check("restart_play", state, S_PLAY);
    endtask

    // Drive ticks through the freeze; respawn must appear right after the 3rd.
    task automatic finish_hit();
        for (int t = 1; t <= 3; t++) begin
            repeat (3) cyc(1'b0);
            check("freeze_no_early_respawn", respawn, 0);
            cyc(1'b1);
        end
        if (model_lives == 0) begin
            check("over_state", state, S_OVER);
            check("over_game_over", game_over, 1);
            check("over_lives", lives, 0);
            check("over_freeze", freeze, 1);
            model_over = 1'b1;
        end else begin
            check("respawn_after_3rd_tick", respawn, 1);
            cyc(1'b0);
            cyc(1'b1);
            check("back_to_play", state, S_PLAY);
        end
    endtask

    task automatic run_vector(input vec_t v);
        logic       seen;
        logic [1:0] g;
        int         pulses;
        logic [2:0] exp_v;
        if (model_over) restart();
        player_x = v.px;
        player_y = v.py;
        ghost_x_flat = v.gxf;
        ghost_y_flat = v.gyf;
        exp_q.push_back({v.exp_hit, v.exp_ghost});
        seen = 1'b0;
        g = 2'd0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            if (hit_pulse) begin
                pulses++;
                seen = 1'b1;
                g = hit_ghost;
            end
        end
        exp_v = exp_q.pop_front();
        check({v.name, "_hit_ghost"}, {seen, g}, exp_v);
        check({v.name, "_pulses"}, pulses, v.exp_hit ? 1 : 0);
        all_far();
        if (v.exp_hit) begin
            model_lives--;
            check({v.name, "_lives"}, lives, model_lives);
            check({v.name, "_freeze"}, freeze, 1);
            finish_hit();
        end else begin
            check({v.name, "_still_play"}, state, S_PLAY);
            check({v.name, "_lives_kept"}, lives, model_lives);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mkv("g2_near",      100, 100, 2, 110,  95, -1,   0,   0, 1'b1, 2);
        vecs[1] = mkv("dx11",         100, 100, 0, 111, 100, -1,   0,   0, 1'b0, 0);
        vecs[2] = mkv("no_wrap",        0,   0, 1, 630,   0, -1,   0,   0, 1'b0, 0);
        vecs[3] = mkv("g1_g3_both",   100, 100, 1,  90, 110,  3, 100, 100, 1'b1, 1);
        vecs[4] = mkv("dy11",          50,  50, 0,  50,  61, -1,   0,   0, 1'b0, 0);
        vecs[5] = mkv("corner_edge",  639, 479, 3, 629, 469, -1,   0,   0, 1'b1, 3);
        vecs[6] = mkv("g0_g1_both",   300, 200, 0, 290, 210,  1, 290, 210, 1'b1, 0);

        all_far();
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("rst_state", state, S_IDLE);
        check("rst_freeze", freeze, 1);
        check("rst_respawn", respawn, 0);
        check("rst_hit_pulse", hit_pulse, 0);
        check("rst_hit_ghost", hit_ghost, 0);
        check("rst_lives", lives, 0);
        check("rst_game_over", game_over, 0);

        reset = 1'b0;
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
        check("start_respawn", respawn, 1);
        check("start_freeze", freeze, 1);
        check("start_lives", lives, 3);
        cyc(1'b0);
        check("grace_state", state, S_GRACE);
        check("grace_respawn_low", respawn, 0);
        check("grace_freeze", freeze, 0);
        cyc(1'b0);
        check("grace_waits_tick", state, S_GRACE);
        cyc(1'b1);
        check("play_state", state, S_PLAY);
        check("play_freeze", freeze, 0);
        model_lives = 3;

        for (int i = 0; i < 7; i++) run_vector(vecs[i]);

        // Hit and tick land on the same edge: counter loads and still needs 3 ticks.
        put_ghost(0, 300, 200);
        cyc(1'b0);
        cyc(1'b1);
        check("hit_tick_pulse", hit_pulse, 1);
        check("hit_tick_state", state, S_HIT);
        model_lives--;
        all_far();
        repeat (2) begin
            repeat (2) cyc(1'b0);
            cyc(1'b1);
        end
        check("hit_tick_still_hit", state, S_HIT);
        repeat (2) cyc(1'b0);
        cyc(1'b1);
        check("hit_tick_respawn", respawn, 1);

        // A catch sitting on the player through GRACE costs nothing.
        put_ghost(0, 300, 200);
        cyc(1'b0);
        repeat (3) cyc(1'b0);
        check("grace_hit_state", state, S_GRACE);
        check("grace_hit_lives", lives, model_lives);
        all_far();
        repeat (2) cyc(1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        check("grace_hit_play", state, S_PLAY);
        check("grace_hit_no_loss", lives, model_lives);

        // Reset in the middle of HIT, then in the middle of RESPAWN.
        put_ghost(2, 305, 195);
        cyc(1'b0);
        cyc(1'b0);
        check("pre_reset_hit", state, S_HIT);
        check("pre_reset_ghost", hit_ghost, 2);
        reset = 1'b1;
        cyc(1'b1);
        check("reset_hit_state", state, S_IDLE);
        check("reset_hit_respawn", respawn, 0);
        check("reset_hit_lives", lives, 0);
        check("reset_hit_freeze", freeze, 1);
        reset = 1'b0;
        all_far();
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
        check("pre_reset_respawn", respawn, 1);
        reset = 1'b1;
        cyc(1'b0);
        check("reset_respawn_state", state, S_IDLE);
        check("reset_respawn_pulse", respawn, 0);
        reset = 1'b0;
        cyc(1'b0);
        check("idle_stays", state, S_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
